// File: rtl/note_pkg.sv
// Shared constants and the note-to-phase-step table for the voice scheduler.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package note_pkg;

    localparam int NUM_NOTES = 10;
    localparam int NOTE_W    = 4;

    typedef logic [NOTE_W-1:0] note_idx_t;

    // Phase increment per 50 MHz clock: round(f * 2^32 / 50e6), C4..E5.
    function automatic logic [31:0] note_step(input note_idx_t n);
        logic [31:0] s;
        case (n)
            4'd0:    s = 32'd22474;  // C4
            4'd1:    s = 32'd25226;  // D4
            4'd2:    s = 32'd28315;  // E4
            4'd3:    s = 32'd29999;  // F4
            4'd4:    s = 32'd33673;  // G4
            4'd5:    s = 32'd37796;  // A4
            4'd6:    s = 32'd42424;  // B4
            4'd7:    s = 32'd44948;  // C5
            4'd8:    s = 32'd50452;  // D5
            4'd9:    s = 32'd56630;  // E5
            default: s = 32'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/voice_osc.sv
// Square-wave oscillator voice: 32b phase accumulator, +/-AMPLITUDE on phase[31].
// Latency: wave follows phase combinationally; phase advances one step per clock while run.
// Backpressure: none. Ports: Clk, resetn (sync, active-low), run, clear (phase := 0), step -> wave.
module voice_osc #(
    parameter int AMPLITUDE = 10000000
) (
    input  logic               Clk,
    input  logic               resetn,
    input  logic               run,
    input  logic               clear,
    input  logic [31:0]        step,
    output logic signed [31:0] wave
);

    localparam logic signed [31:0] AMP = 32'(AMPLITUDE);

    logic [31:0] phase_q, phase_d;

    // Clear wins so a freshly allocated voice always starts at phase 0;
    // a released voice simply holds its phase.
    always_comb begin
        phase_d = phase_q;
        if (clear)
            phase_d = '0;
        else if (run)
            phase_d = phase_q + step;
    end

    always_ff @(posedge Clk) begin
        if (!resetn)
            phase_q <= '0;
        else
            phase_q <= phase_d;
    end

    always_comb begin
        wave = '0;
        if (run)
            wave = phase_q[31] ? -AMP : AMP;
    end

endmodule

// File: rtl/note_voice_scheduler.sv
// Polyphonic scheduler: 10 note keys share NUM_VOICES square voices; mixed, saturated, paced samples.
// Latency: key to voice <= 1 + 10 cycles; voice to mix 1 cycle; one sample latched per SAMPLE_DIV clocks.
// Backpressure: sample held while audio_out_allowed=0; a new tick overwrites it and pulses sample_overrun.
module note_voice_scheduler
    import note_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AMPLITUDE  = 10000000,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                  Clk,
    input  logic                  resetn,
    input  logic [NUM_NOTES-1:0]  note_keys,
    input  logic                  audio_out_allowed,
    output logic                  write_audio_out,
    output logic signed [31:0]    left_channel_out,
    output logic signed [31:0]    right_channel_out,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  note_dropped,
    output logic                  sample_overrun
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic signed [34:0] MIX_MAX = 35'sd2147483647;
    localparam logic signed [34:0] MIX_MIN = -35'sd2147483648;

    // ---------------- key scanner / voice allocation ----------------
    logic [NUM_NOTES-1:0]  keys_q;
    note_idx_t             scan_q, scan_d;
    logic [NUM_VOICES-1:0] busy_q, busy_d, clear_v;
    note_idx_t             note_q [NUM_VOICES];
    note_idx_t             note_d [NUM_VOICES];
    // mark_q[i]: key i was refused a voice during this press; it stays
    // unallocated (and unreported) until released.
    logic [NUM_NOTES-1:0]  mark_q, mark_d;
    logic                  drop_q, drop_d;
    logic                  owned, free_found;
    logic [VW-1:0]         owner, free_idx;

    always_comb begin
        busy_d     = busy_q;
        note_d     = note_q;
        mark_d     = mark_q;
        clear_v    = '0;
        drop_d     = 1'b0;
        owned      = 1'b0;
        owner      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (busy_q[v] && note_q[v] == scan_q) begin
                owned = 1'b1;
                owner = VW'(v);
            end
        end
        // Descending walk leaves the lowest free index.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!busy_q[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
        end
        if (keys_q[scan_q]) begin
            if (!owned && !mark_q[scan_q]) begin
                if (free_found) begin
                    busy_d[free_idx]  = 1'b1;
                    note_d[free_idx]  = scan_q;
                    clear_v[free_idx] = 1'b1;
                end else begin
                    drop_d         = 1'b1;
                    mark_d[scan_q] = 1'b1;
                end
            end
        end else begin
            mark_d[scan_q] = 1'b0;
            if (owned)
                busy_d[owner] = 1'b0;
        end
        scan_d = (scan_q == NOTE_W'(NUM_NOTES - 1)) ? '0 : scan_q + NOTE_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            keys_q <= '0;
            scan_q <= '0;
            busy_q <= '0;
            mark_q <= '0;
            drop_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++)
                note_q[v] <= '0;
        end else begin
            keys_q <= note_keys;
            scan_q <= scan_d;
            busy_q <= busy_d;
            mark_q <= mark_d;
            drop_q <= drop_d;
            note_q <= note_d;
        end
    end

    // ---------------- voices ----------------
    logic signed [31:0] wave [NUM_VOICES];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_osc #(.AMPLITUDE(AMPLITUDE)) u_osc (
            .Clk    (Clk),
            .resetn (resetn),
            .run    (busy_q[g]),
            .clear  (clear_v[g]),
            .step   (note_step(note_q[g])),
            .wave   (wave[g])
        );
    end

    // ---------------- mixer (35b sum, saturate to 32b) ----------------
    logic signed [34:0] mix_sum;
    logic signed [31:0] mix_d, mix_q;

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            mix_sum = mix_sum + 35'(wave[v]);
        if (mix_sum > MIX_MAX)
            mix_d = 32'sh7FFFFFFF;
        else if (mix_sum < MIX_MIN)
            mix_d = 32'sh80000000;
        else
            mix_d = mix_sum[31:0];
    end

    // ---------------- sample pacing / handshake ----------------
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic signed [31:0] sample_q;
    logic               tick, handshake;

    assign tick      = (cnt_q == CW'(SAMPLE_DIV - 1));
    assign handshake = pending_q && audio_out_allowed;

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        // On a tick the fresh sample is pending regardless of a same-cycle
        // write, which consumed the previous sample.
        pending_d = tick ? 1'b1 : (handshake ? 1'b0 : pending_q);
        overrun_d = tick && pending_q && !audio_out_allowed;
    end

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            mix_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            sample_q  <= '0;
        end else begin
            mix_q     <= mix_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (tick)
                sample_q <= mix_q;
        end
    end

    assign write_audio_out   = handshake;
    assign left_channel_out  = sample_q;
    assign right_channel_out = sample_q;
    assign voice_busy        = busy_q;
    assign note_dropped      = drop_q;
    assign sample_overrun    = overrun_q;

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Bench for note_voice_scheduler: directed key patterns, scoreboard of expected written samples.
// Runs with a short sample period and AMPLITUDE=1e9 so saturation is reachable with 3+ voices.
module tb_note_voice_scheduler;

    localparam int NV   = 4;
    localparam int AMP  = 1000000000;
    localparam int SDIV = 32;

    localparam logic [31:0] ONE  = 32'd1000000000;
    localparam logic [31:0] TWO  = 32'd2000000000;
    localparam logic [31:0] SATP = 32'h7FFFFFFF;

    logic              Clk = 1'b0;
    logic              resetn = 1'b0;
    logic [9:0]        note_keys = '0;
    logic              audio_out_allowed = 1'b0;
    logic              write_audio_out;
    logic signed [31:0] left_channel_out, right_channel_out;
    logic [NV-1:0]     voice_busy;
    logic              note_dropped, sample_overrun;

    note_voice_scheduler #(.NUM_VOICES(NV), .AMPLITUDE(AMP), .SAMPLE_DIV(SDIV)) dut (
        .Clk               (Clk),
        .resetn            (resetn),
        .note_keys         (note_keys),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .left_channel_out  (left_channel_out),
        .right_channel_out (right_channel_out),
        .voice_busy        (voice_busy),
        .note_dropped      (note_dropped),
        .sample_overrun    (sample_overrun)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int unsigned wr_cyc[$];
    int unsigned cyc = 0;
    int          drop_cnt = 0;
    int          ovr_cnt = 0;

    // Clock edges since reset release; sample counter phase is cyc % SDIV.
    always @(posedge Clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard on every write strobe, counts pulses.
    always @(negedge Clk) begin
        if (resetn && note_dropped)   drop_cnt++;
        if (resetn && sample_overrun) ovr_cnt++;
        if (write_audio_out) begin
            checks++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got L=%0h R=%0h, no write expected at cyc %0d",
                         left_channel_out, right_channel_out, cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (left_channel_out !== e || right_channel_out !== e) begin
                    errors++;
                    $display("FAIL sample_value: got L=%0h R=%0h expected %0h",
                             left_channel_out, right_channel_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_mod(input int unsigned m);
        do begin
            @(posedge Clk);
            #1;
        end while ((cyc % SDIV) != m);
    endtask

    // One-cycle allowed pulse; a sample must be pending and must be e.
    task automatic do_write(input string name, input logic [31:0] e);
        exp_q.push_back(e);
        audio_out_allowed = 1'b1;
        cycles(1);
        audio_out_allowed = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge Clk);
            k++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, o0, n0;
        cycles(3);
        // Reset state
        check("rst_busy",    voice_busy, 0);
        check("rst_write",   write_audio_out, 0);
        check("rst_left",    left_channel_out, 0);
        check("rst_right",   right_channel_out, 0);
        check("rst_drop",    note_dropped, 0);
        check("rst_overrun", sample_overrun, 0);
        resetn = 1'b1;

        // Single note C4 -> voice 0 within 11 cycles
        note_keys = 10'h001;
        cycles(11);
        check("c4_alloc_latency", voice_busy, 4'b0001);
        cycles(60);
        do_write("c4_sample", ONE);

        // Four notes fill all voices; 4e9 saturates positive
        note_keys = 10'h00F;
        cycles(70);
        check("four_busy", voice_busy, 4'b1111);
        do_write("four_sat", SATP);

        // G4 pressed with no voice free: one drop, reported once
        d0 = drop_cnt;
        note_keys = 10'h01F;
        cycles(70);
        check("g4_drop_once", drop_cnt - d0, 1);
        check("g4_busy_full", voice_busy, 4'b1111);
        cycles(100);
        check("g4_drop_still_once", drop_cnt - d0, 1);

        // Release C4: G4 stays unallocated while still held
        note_keys = 10'h01E;
        cycles(70);
        check("c4_release_busy", voice_busy, 4'b1110);
        do_write("three_sat", SATP);
        note_keys = 10'h010;
        cycles(70);
        check("g4_not_alloc", voice_busy, 4'b0000);
        do_write("g4_silent", 32'd0);

        // Re-press G4: now it gets voice 0
        note_keys = 10'h000;
        cycles(30);
        note_keys = 10'h010;
        cycles(70);
        check("g4_repress_busy", voice_busy, 4'b0001);
        do_write("g4_sample", ONE);
        check("g4_no_new_drop", drop_cnt - d0, 1);

        // Two voices, unsaturated sum
        note_keys = 10'h000;
        cycles(30);
        note_keys = 10'h003;
        cycles(70);
        check("two_busy", voice_busy, 4'b0011);
        wait_mod(5);
        do_write("two_sum", TWO);

        // Backpressure across three ticks; mix changes before tick 2
        o0 = ovr_cnt;
        cycles(30);
        note_keys = 10'h001;
        cycles(66);
        check("overrun_count", ovr_cnt - o0, 2);
        do_write("overrun_latest", ONE);

        // Tick coincident with handshake: old sample written, new one pending
        wait_mod(1);
        note_keys = 10'h003;
        wait_mod(5);
        o0 = ovr_cnt;
        exp_q.push_back(ONE);
        wait_mod(SDIV - 1);
        audio_out_allowed = 1'b1;
        cycles(1);
        audio_out_allowed = 1'b0;
        check("coincident_old", exp_q.size(), 0);
        cycles(3);
        check("coincident_no_overrun", ovr_cnt - o0, 0);
        do_write("coincident_new", TWO);

        // Reset while pending with two voices busy
        cycles(40);
        resetn = 1'b0;
        cycles(1);
        check("mid_rst_busy",  voice_busy, 0);
        check("mid_rst_write", write_audio_out, 0);
        check("mid_rst_left",  left_channel_out, 0);
        check("mid_rst_right", right_channel_out, 0);
        resetn = 1'b1;
        audio_out_allowed = 1'b1;
        n0 = wr_cyc.size();
        exp_q.push_back(TWO);
        exp_q.push_back(TWO);
        cycles(20);
        check("no_write_after_rst", exp_q.size(), 2);
        wait_drain("post_rst_writes", 120);
        audio_out_allowed = 1'b0;
        if (wr_cyc.size() >= n0 + 2) begin
            check("first_write_cyc", wr_cyc[n0], SDIV);
            check("write_period", wr_cyc[n0 + 1] - wr_cyc[n0], SDIV);
        end else begin
            checks++;
            errors++;
            $display("FAIL write_period: got %0d writes expected 2", wr_cyc.size() - n0);
        end

        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
